// File: rtl/tft_spi_tx_if.sv
// tft_spi_tx_if: word handshake between a producer and the TFT SPI transmitter.
//   s_data  : word to transmit (DATA_W bits)
//   s_dc    : register select, 0 = command, 1 = data
//   s_last  : this word closes the frame
//   s_valid : word offered by the producer
//   s_ready : transmitter accepts the word on a rising edge with s_valid high
// Modports: master = word producer, slave = transmitter.
interface tft_spi_tx_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] s_data;
  logic              s_dc;
  logic              s_last;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_dc, output s_last, output s_valid, input s_ready);
  modport slave  (input s_data, input s_dc, input s_last, input s_valid, output s_ready);
endinterface

// File: rtl/tft_spi_tx.sv
// tft_spi_tx: SPI (mode 0) write-only transmitter for TFT panel controllers.
// Words arrive over a valid/ready handshake and are shifted out MSB first.
// Register select is sent either as a start byte {011100, dc, 0} once per
// frame (START_BYTE_EN=1) or on the dc pin (START_BYTE_EN=0). Consecutive
// words with the same register select share one chip-select frame.
// Ports:
//   SPI_CLK : the only clock, rising-edge
//   reset   : asynchronous active-high reset
//   s_if    : word handshake (slave side): s_data, s_dc, s_last, s_valid, s_ready
//   sclk    : SPI clock, idles low
//   mosi    : serial data, MSB first
//   cs_n    : active-low chip select
//   dc      : register-select pin (held 0 when START_BYTE_EN=1)
//   busy    : high whenever the FSM is not IDLE
module tft_spi_tx #(
  parameter int DATA_W        = 16,
  parameter int CLK_DIV       = 2,
  parameter int START_BYTE_EN = 1,
  parameter int CS_GAP        = 2
) (
  input  logic            SPI_CLK,
  input  logic            reset,
  tft_spi_tx_if.slave     s_if,
  output logic            sclk,
  output logic            mosi,
  output logic            cs_n,
  output logic            dc,
  output logic            busy
);

  localparam int BITS_MAX = (DATA_W > 8) ? DATA_W : 8;
  localparam int BIT_W    = $clog2(BITS_MAX);
  localparam int CNT_W    = $clog2(2 * CLK_DIV);
  localparam int GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [CNT_W-1:0] CNT_RISE = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] SB_LAST  = BIT_W'(7);
  localparam logic [BIT_W-1:0] DW_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_GAP > 1) ? (CS_GAP - 1) : 0);
  localparam logic             SBE      = (START_BYTE_EN != 0);
  localparam logic [5:0]       SB_HEAD  = 6'b011100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIT_W-1:0]    r_bit;
  logic [GAP_W-1:0]    r_gap;
  logic                r_sclk;
  logic                r_mosi;
  logic                r_cs_n;
  logic                r_dc;
  logic                r_busy;
  logic                r_s_ready;

  // Word and start-byte shift registers; they are always reloaded on a
  // handshake before being used, so they carry no reset.
  logic [DATA_W-1:0]   r_sh;
  logic [6:0]          r_sb;     // start byte below its MSB (MSB goes out at accept)
  logic                r_last;
  logic                r_dc_frame;

  logic                w_dc_mismatch;
  logic                w_ready;
  logic                w_accept;
  logic                w_bit_end;

  // A word waiting in HOLD with a different register select must not be
  // taken into the open frame: it is refused here and picked up from IDLE
  // once the frame has been closed.
  assign w_dc_mismatch = SBE && (r_state == ST_HOLD) && s_if.s_valid &&
                         (s_if.s_dc != r_dc_frame);
  assign w_ready       = r_s_ready & ~w_dc_mismatch;
  assign w_accept      = s_if.s_valid & w_ready;
  assign w_bit_end     = ((r_state == ST_START) || (r_state == ST_DATA)) &&
                         (r_cnt == CNT_END);

  assign s_if.s_ready  = w_ready;
  assign sclk          = r_sclk;
  assign mosi          = r_mosi;
  assign cs_n          = r_cs_n;
  assign dc            = r_dc;
  assign busy          = r_busy;

  // Datapath: load on handshake, shift one bit at every bit boundary.
  always_ff @(posedge SPI_CLK) begin
    if (w_accept) begin
      r_sh       <= s_if.s_data;
      r_last     <= s_if.s_last;
      r_dc_frame <= s_if.s_dc;
      r_sb       <= {SB_HEAD[4:0], s_if.s_dc, 1'b0};
    end else if (w_bit_end) begin
      if (r_state == ST_START) begin
        r_sb <= {r_sb[5:0], 1'b0};
      end else begin
        r_sh <= {r_sh[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Control FSM; every pin is a register updated here.
  always_ff @(posedge SPI_CLK or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_gap     <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_dc      <= 1'b0;
      r_busy    <= 1'b0;
      r_s_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sclk <= 1'b0;
          r_cnt  <= '0;
          r_bit  <= '0;
          if (w_accept) begin
            // First bit is driven together with the falling cs_n.
            r_cs_n    <= 1'b0;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b1;
            if (SBE) begin
              r_state <= ST_START;
              r_mosi  <= SB_HEAD[5];
            end else begin
              r_state <= ST_DATA;
              r_mosi  <= s_if.s_data[DATA_W-1];
              r_dc    <= s_if.s_dc;
            end
          end else begin
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
          end
        end

        ST_START, ST_DATA: begin
          if (r_cnt == CNT_RISE) begin
            r_sclk <= 1'b1;
          end
          if (w_bit_end) begin
            r_sclk <= 1'b0;
            r_cnt  <= '0;
            if (r_state == ST_START) begin
              if (r_bit == SB_LAST) begin
                r_state <= ST_DATA;
                r_bit   <= '0;
                r_mosi  <= r_sh[DATA_W-1];
              end else begin
                r_bit  <= r_bit + BIT_W'(1);
                r_mosi <= r_sb[6];
              end
            end else if (r_bit == DW_LAST) begin
              r_bit  <= '0;
              r_mosi <= 1'b0;
              if (r_last) begin
                r_state <= ST_GAP;
                r_cs_n  <= 1'b1;
                r_gap   <= '0;
              end else begin
                r_state   <= ST_HOLD;
                r_s_ready <= 1'b1;
              end
            end else begin
              r_bit  <= r_bit + BIT_W'(1);
              r_mosi <= r_sh[DATA_W-2];
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_HOLD: begin
          r_sclk <= 1'b0;
          r_cnt  <= '0;
          r_bit  <= '0;
          if (w_accept) begin
            // Continue the open frame without a start byte.
            r_state   <= ST_DATA;
            r_mosi    <= s_if.s_data[DATA_W-1];
            r_s_ready <= 1'b0;
            if (!SBE) begin
              r_dc <= s_if.s_dc;
            end
          end else if (w_dc_mismatch) begin
            r_state   <= ST_GAP;
            r_cs_n    <= 1'b1;
            r_mosi    <= 1'b0;
            r_s_ready <= 1'b0;
            r_gap     <= '0;
          end else begin
            r_mosi <= 1'b0;
          end
        end

        ST_GAP: begin
          r_sclk <= 1'b0;
          r_mosi <= 1'b0;
          r_cs_n <= 1'b1;
          if (r_gap == GAP_LAST) begin
            r_state   <= ST_IDLE;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
            r_gap     <= '0;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_sclk    <= 1'b0;
          r_mosi    <= 1'b0;
          r_cs_n    <= 1'b1;
          r_s_ready <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tft_spi_tx.md
TFT_SPI_TX -- requirements
Module: tft_spi_tx

Interface
REQ-001 Parameter DATA_W, default 16, payload bits per word (8..32).
REQ-002 Parameter CLK_DIV, default 2, SPI_CLK cycles per sclk half-period (>=1).
REQ-003 Parameter START_BYTE_EN, default 1; 1 = register select is carried in a start byte, 0 = register select is driven on the dc pin.
REQ-004 Parameter CS_GAP, default 2, minimum SPI_CLK cycles cs_n is held high between frames.
REQ-005 Port SPI_CLK, input, 1, the only clock; all logic updates on its rising edge.
REQ-006 Port reset, input, 1, asynchronous active-high reset.
REQ-007 Port s_data, input, DATA_W, word to transmit.
REQ-008 Port s_dc, input, 1, register select: 0 = command, 1 = data.
REQ-009 Port s_last, input, 1, closes the frame (cs_n released) after this word.
REQ-010 Port s_valid, input, 1, word offered.
REQ-011 Port s_ready, output, 1, word accepted when s_valid and s_ready are both high on a rising edge.
REQ-012 Port sclk, output, 1, SPI clock, mode 0 (idles low).
REQ-013 Port mosi, output, 1, serial data, MSB first.
REQ-014 Port cs_n, output, 1, active-low chip select.
REQ-015 Port dc, output, 1, register-select pin; held 0 when START_BYTE_EN=1.
REQ-016 Port busy, output, 1, high in any state other than IDLE.

Function
REQ-017 The FSM states shall be IDLE, START, DATA, HOLD and GAP, all outputs registered.
REQ-018 IDLE: s_ready=1, cs_n=1, sclk=0, mosi=0; an accepted word latches data, dc and last, sets cs_n=0 on the next cycle, and enters START if START_BYTE_EN=1, else DATA.
REQ-019 When START_BYTE_EN=0, the dc pin shall be updated in the same cycle cs_n falls and held stable for the whole frame.
REQ-020 START shall shift the 8-bit start byte {6'b011100, dc, 1'b0} MSB first, so dc=0 gives 0x70 and dc=1 gives 0x72.
REQ-021 START shall occur only once per frame, at the first word of the frame.
REQ-022 DATA shall shift DATA_W bits MSB first.
REQ-023 Each bit shall span 2*CLK_DIV cycles: mosi changes at the bit start with sclk low, sclk rises after CLK_DIV cycles, and sclk falls at the bit end.
REQ-024 The first mosi bit shall be valid in the same cycle cs_n first goes low.
REQ-025 A word shall be accepted at most once, and s_ready shall be 0 throughout START and DATA.
REQ-026 After the final sclk fall of a word: if the latched last=1, the block enters GAP; otherwise it enters HOLD.
REQ-027 HOLD: cs_n=0, sclk=0, mosi=0, s_ready=1; the next word may wait in HOLD indefinitely.
REQ-028 In HOLD, an accepted word whose dc equals the frame dc (or any word when START_BYTE_EN=0) enters DATA on the next cycle with no start byte.
REQ-029 In HOLD, when START_BYTE_EN=1 and s_valid=1 with s_dc differing from the frame dc, s_ready shall be 0 and the block enters GAP; the word is then accepted from IDLE as a new frame.
REQ-030 When START_BYTE_EN=0 and dc changes in HOLD, the dc pin shall update in the acceptance cycle, before the first sclk rise.
REQ-031 GAP: cs_n=1, sclk=0, s_ready=0 for exactly CS_GAP cycles, then IDLE.
REQ-032 Bit and divider counters shall be sized with $clog2 of their range and shall never wrap inside a word.
REQ-033 Changes on s_data, s_dc and s_last while no handshake occurs shall have no effect.

Reset
REQ-034 Asserting reset shall immediately force IDLE with cs_n=1, sclk=0, mosi=0, dc=0, s_ready=0 and busy=0, aborting any word in flight with no further sclk edges.
REQ-035 s_ready shall go to 1 on the first rising edge after reset deasserts.

Verification
REQ-036 Defaults; 0xA55A, dc=1, last=1 -> mosi 0x72 then 0xA55A, 24 sclk rises, cs_n low for 96 cycles, then high for 2 cycles.
REQ-037 Defaults; 0x1234 then 0x5678, both dc=1, second last=1 -> one start byte 0x72, 40 rises, cs_n continuously low.
REQ-038 Defaults; 0x002C dc=0 last=0, then 0xFFFF dc=1 -> first frame closes, cs_n high for 2 cycles, second frame starts with 0x72.
REQ-039 START_BYTE_EN=0, DATA_W=9, CLK_DIV=1; 0x1AB, dc=0, last=1 -> dc=0 as cs_n falls, 9 rises, no start byte.
REQ-040 Assert reset at bit 10 of a word -> next cycle cs_n=1, sclk=0, mosi=0; after release, s_ready=1 and a fresh word transmits correctly.
REQ-041 Hold s_valid high during a word -> s_ready=0 until HOLD/IDLE; exactly one handshake per word; no word lost or duplicated.
